// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I core control path.
// Opcode constants are also consumed by decode.
package core_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_HALT
  } state_e;

  function automatic logic op_legal(
    input logic [6:0] op
  );
    logic r;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR,
      OP_LUI, OP_AUIPC: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_mem(
    input logic [6:0] op
  );
    return (op == OP_LOAD) ||
           (op == OP_STORE);
  endfunction

  function automatic logic op_writes_rd(
    input logic [6:0] op
  );
    return op_legal(op) &&
           (op != OP_STORE) &&
           (op != OP_BRANCH);
  endfunction

endpackage

// File: rtl/core_control_if.sv
// Instruction and data memory handshake bundle.
// master = core side, slave = memory side.
interface core_control_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ready
  );

endinterface

// File: rtl/core_next_pc.sv
// Next program counter selection for the writeback stage.
// Purely combinational; the caller decides when to load it.
module core_next_pc
  import core_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [31:0] pc,
  input  logic [31:0] alu_result,
  input  logic        branch_taken,
  output logic [31:0] next_pc
);

  logic is_jal;
  logic is_br;
  logic is_jalr;

  assign is_jal  = (opcode == OP_JAL);
  assign is_br   = (opcode == OP_BRANCH);
  assign is_jalr = (opcode == OP_JALR);

  always_comb begin
    next_pc = pc + 32'd4;
    unique case (1'b1)
      is_jal:                next_pc = alu_result;
      is_br && branch_taken: next_pc = alu_result;
      is_jalr:               next_pc = {alu_result[31:1], 1'b0};
      default:               next_pc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/core_control.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer.
// Owns pc and ir; every output is a flop.
module core_control
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  core_control_if.master        bus,
  output logic [31:0]           ir,
  output logic [31:0]           pc,
  input  logic [31:0]           alu_result,
  input  logic                  branch_taken,
  output logic                  rf_we,
  output logic                  retire,
  output logic                  illegal
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;
  logic        imem_req_q, imem_req_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic        rf_we_q, rf_we_d;
  logic        retire_q, retire_d;

  logic [6:0]  op;
  logic [31:0] next_pc;
  logic        wr_rd;

  assign op    = ir_q[6:0];
  assign wr_rd = op_writes_rd(op) &&
                 (ir_q[11:7] != 5'd0);

  core_next_pc u_next_pc (
    .opcode       (op),
    .pc           (pc_q),
    .alu_result   (alu_result),
    .branch_taken (branch_taken),
    .next_pc      (next_pc)
  );

  // Outputs are computed for the state being entered.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    illegal_d  = illegal_q;
    imem_req_d = 1'b0;
    dmem_req_d = 1'b0;
    dmem_we_d  = 1'b0;
    rf_we_d    = 1'b0;
    retire_d   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_rdata;
          state_d = S_DECODE;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (op_legal(op)) begin
          state_d = S_EXECUTE;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXECUTE: begin
        if (op_is_mem(op)) begin
          state_d    = S_MEMORY;
          dmem_req_d = 1'b1;
          dmem_we_d  = (op == OP_STORE);
        end else begin
          state_d  = S_WRITEBACK;
          rf_we_d  = wr_rd;
          retire_d = 1'b1;
        end
      end
      S_MEMORY: begin
        if (bus.dmem_ready) begin
          state_d  = S_WRITEBACK;
          rf_we_d  = wr_rd;
          retire_d = 1'b1;
        end else begin
          dmem_req_d = 1'b1;
          dmem_we_d  = (op == OP_STORE);
        end
      end
      S_WRITEBACK: begin
        pc_d       = next_pc;
        state_d    = S_FETCH;
        imem_req_d = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 32'd0;
      illegal_q  <= 1'b0;
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      retire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      illegal_q  <= illegal_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
      retire_q   <= retire_d;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.dmem_req  = dmem_req_q;
  assign bus.dmem_we   = dmem_we_q;
  assign ir            = ir_q;
  assign pc            = pc_q;
  assign rf_we         = rf_we_q;
  assign retire        = retire_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_core_control.sv
// Scoreboard bench for core_control: stimulus queues expected
// retirements, a monitor pops them on each retire pulse.
module tb_core_control;

  logic        clk;
  logic        rst;
  logic [31:0] ir;
  logic [31:0] pc;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic        rf_we;
  logic        retire;
  logic        illegal;

  core_control_if bus ();

  core_control dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .ir           (ir),
    .pc           (pc),
    .alu_result   (alu_result),
    .branch_taken (branch_taken),
    .rf_we        (rf_we),
    .retire       (retire),
    .illegal      (illegal)
  );

  typedef struct {
    logic [31:0] epc;
    logic        erf;
    logic [31:0] enpc;
    int          ecyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          failures;
  int          cyc;
  logic [31:0] model_pc;
  logic        pend;
  logic [31:0] pend_npc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: retire pulses against the scoreboard, then the
  // pc presented in the following fetch.
  initial pend = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (pend) begin
        chk("next_pc", pc, pend_npc);
        chk("next_fetch_req", 32'(bus.imem_req), 32'd1);
        pend = 1'b0;
      end
      if (rf_we)
        chk("rf_we_only_with_retire", 32'(retire), 32'd1);
      if (retire) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("retire_pc", pc, e.epc);
          chk("retire_rf_we", 32'(rf_we), 32'(e.erf));
          chk("retire_cycle", 32'(cyc), 32'(e.ecyc));
          pend     = 1'b1;
          pend_npc = e.enpc;
        end
      end
    end
  end

  task automatic do_reset();
    rst            = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    model_pc = 32'h0;
  endtask

  task automatic run_instr(
    input logic [31:0] inst,
    input int          iwait,
    input logic        is_mem,
    input int          dwait,
    input logic        exp_we,
    input logic        taken,
    input logic [31:0] alu,
    input logic        exp_rf,
    input logic [31:0] exp_npc,
    input int          lat
  );
    exp_t e;
    e.epc  = model_pc;
    e.erf  = exp_rf;
    e.enpc = exp_npc;
    e.ecyc = cyc + lat - 1;
    exp_q.push_back(e);
    bus.imem_rdata = inst;
    alu_result     = alu;
    branch_taken   = taken;
    for (int i = 0; i < iwait; i++) begin
      chk("fetch_req_wait", 32'(bus.imem_req), 32'd1);
      chk("fetch_addr_wait", bus.imem_addr, model_pc);
      @(negedge clk);
    end
    chk("fetch_req", 32'(bus.imem_req), 32'd1);
    chk("fetch_addr", bus.imem_addr, model_pc);
    bus.imem_ready = 1'b1;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    chk("ir_latch", ir, inst);
    chk("decode_no_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    if (is_mem) begin
      @(negedge clk);
      for (int i = 0; i <= dwait; i++) begin
        chk("dmem_req", 32'(bus.dmem_req), 32'd1);
        chk("dmem_we", 32'(bus.dmem_we), 32'(exp_we));
        chk("ir_stable", ir, inst);
        if (i == dwait) bus.dmem_ready = 1'b1;
        @(negedge clk);
      end
      bus.dmem_ready = 1'b0;
    end else begin
      @(negedge clk);
    end
    chk("wb_no_dmem_req", 32'(bus.dmem_req), 32'd0);
    @(negedge clk);
    model_pc = exp_npc;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    bus.imem_rdata = 32'h0;
    alu_result     = 32'h0;
    branch_taken   = 1'b0;
    @(negedge clk);
    do_reset();

    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd1);
    chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);

    // inst, iwait, mem, dwait, we, taken, alu, rf, next_pc, lat
    run_instr(32'h002081b3, 0, 0, 0, 0, 0, 32'h0,
              1, 32'h4, 4);
    run_instr(32'h002081b3, 3, 0, 0, 0, 0, 32'h0,
              1, 32'h8, 7);
    run_instr(32'h00208063, 0, 0, 0, 0, 0, 32'h40,
              0, 32'hC, 4);
    run_instr(32'h008000ef, 0, 0, 0, 0, 0, 32'h8,
              1, 32'h8, 4);
    run_instr(32'h00208063, 0, 0, 0, 0, 1, 32'h40,
              0, 32'h40, 4);
    run_instr(32'h000080e7, 0, 0, 0, 0, 0, 32'h101,
              1, 32'h100, 4);
    run_instr(32'h0000a283, 0, 1, 2, 0, 0, 32'h200,
              1, 32'h104, 7);
    run_instr(32'h0020a223, 0, 1, 0, 1, 0, 32'h204,
              0, 32'h108, 5);
    run_instr(32'h00208033, 0, 0, 0, 0, 0, 32'h0,
              0, 32'h10C, 4);
    run_instr(32'h123453b7, 0, 0, 0, 0, 1, 32'h999,
              1, 32'h110, 4);

    // Reset while a load sits in MEMORY.
    bus.imem_rdata = 32'h0000a283;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem_dmem_req", 32'(bus.dmem_req), 32'd1);
    chk("mid_mem_pc", pc, 32'h110);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mem_pc", pc, 32'h0);
    chk("rst_mem_dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_mem_imem_req", 32'(bus.imem_req), 32'd1);
    rst      = 1'b0;
    model_pc = 32'h0;

    // Wrap of pc+4 at the top of the address space.
    run_instr(32'h008000ef, 0, 0, 0, 0, 0, 32'hFFFFFFFC,
              1, 32'hFFFFFFFC, 4);
    run_instr(32'h00108093, 0, 0, 0, 0, 0, 32'h0,
              1, 32'h0, 4);

    // Unsupported opcode halts the core.
    bus.imem_rdata = 32'hFFFFFFFF;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    chk("ill_ir", ir, 32'hFFFFFFFF);
    @(negedge clk);
    chk("ill_flag", 32'(illegal), 32'd1);
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("halt_imem_req", 32'(bus.imem_req), 32'd0);
      chk("halt_dmem_req", 32'(bus.dmem_req), 32'd0);
      chk("halt_illegal", 32'(illegal), 32'd1);
      @(negedge clk);
    end
    do_reset();
    chk("post_rst_illegal", 32'(illegal), 32'd0);
    chk("post_rst_imem_req", 32'(bus.imem_req), 32'd1);

    for (int i = 0; i < 50 && (exp_q.size() != 0 || pend); i++)
      @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_control.md
# core_control

Multi-cycle sequencer for the RV32I core. It fetches each instruction over a request/ready handshake and latches it into the instruction register that feeds `decode`. It then steps the instruction through execute, memory and writeback, and owns the program counter. It sits between instruction/data memory and the decode/ALU/register-file datapath, and generates every enable those units need.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ready`  in  1  fetch data valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `ir`  out  32  latched instruction, drives `decode.inst`.
- `pc`  out  32  current instruction address.
- `alu_result`  in  32  ALU output: branch/jump target or memory address.
- `branch_taken`  in  1  ALU compare result for the current branch.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data write (store) qualifier for `dmem_req`.
- `dmem_ready`  in  1  data access completes this cycle.
- `rf_we`  out  1  register-file write enable.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `illegal`  out  1  sticky; unsupported opcode fetched, core halted.

## Operation
- States:
  - FETCH: `imem_req`=1, held until `imem_ready`. On ready, `ir` <= `imem_rdata`, go to DECODE.
  - DECODE: one cycle; classify `ir[6:0]`. Supported opcodes go to EXECUTE; any other opcode goes to HALT.
  - EXECUTE: one cycle, ALU evaluates. LOAD/STORE go to MEMORY; all others go to WRITEBACK.
  - MEMORY: `dmem_req`=1 (`dmem_we`=1 for STORE only), held until `dmem_ready`, then WRITEBACK.
  - WRITEBACK: one cycle. `retire`=1, PC updated, then FETCH.
  - HALT: absorbing. `illegal`=1, no requests issued; exits only on `rst`.
- Supported opcodes:
  - R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011.
  - BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- `rf_we`:
  - Asserted in WRITEBACK only, for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC.
  - Suppressed when `ir[11:7]`==0.
  - Never asserted for STORE or BRANCH.
- Next PC, loaded at the end of WRITEBACK:
  - JAL, or BRANCH with `branch_taken`=1: `alu_result`.
  - JALR: `alu_result` with bit 0 cleared.
  - Otherwise: `pc`+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- `branch_taken` is sampled only in WRITEBACK and ignored for non-branches.
- `ir` is stable from the cycle after the FETCH handshake until the next FETCH handshake.
- Misaligned targets are not checked; no alignment exception is raised.

## Timing
- Reset values: state=FETCH, `pc`=RESET_PC, `ir`=0, `illegal`=0.
- Registered outputs:
  - `imem_req` and `dmem_req` reflect state, so `imem_req`=1 in the first cycle after reset.
  - `dmem_we`, `rf_we` and `retire` are 0 outside their states.
- Reset mid-operation: `rst` has priority over every transition. An outstanding request is dropped in the next cycle, and memories must tolerate an abandoned request.
- Handshakes: a request stays high with stable `imem_addr`, `alu_result` and `dmem_we` until the matching ready is seen. Ready arriving while no request is high is ignored.
- Zero-wait latency:
  - R, I-ALU, LUI, AUIPC, JAL, JALR, BRANCH: 4 cycles each (FETCH, DECODE, EXECUTE, WRITEBACK).
  - LOAD, STORE: 5 cycles each.
  - Each wait cycle on either ready adds 1 cycle.
- The `retire` pulse coincides with the `rf_we` pulse and with the final value of `pc` for that instruction. The new `pc` is visible in the next FETCH.

## Structure
- Shared package `core_pkg`:
  - opcode constants (shared with `decode`);
  - the state enumeration;
  - `RESET_PC` default.
- One combinational sub-module, `core_next_pc`: inputs opcode, `pc`, `alu_result`, `branch_taken`; output next PC.
- The FSM and the registers stay in `core_control`.

## Test plan
- Reset, then `imem_rdata`=32'h002081b3 (ADD x3,x1,x2) with `imem_ready` tied high:
  - `ir`=002081b3 after cycle 1;
  - `rf_we`=`retire`=1 in cycle 4 only;
  - `pc`=4 on the next fetch.
- Same ADD with `imem_ready` delayed 3 cycles: `imem_req` high and `imem_addr`=0 for 4 cycles, retire in cycle 7.
- LW x5,0(x1) (0000a283) with `dmem_ready` after 2 cycles: `dmem_req`=1 and `dmem_we`=0 for 2 cycles, then a single `rf_we`.
- SW x2,4(x1) (0020a223): `dmem_we`=1 during MEMORY; `rf_we` never asserted.
- BEQ at `pc`=8 with `alu_result`=0x40:
  - `branch_taken`=1 gives next `pc`=0x40;
  - `branch_taken`=0 gives 0xC.
- Boundary cases:
  - `imem_rdata`=0xFFFFFFFF sets `illegal`=1, and no `imem_req` follows for 20 cycles.
  - ADD x0,x1,x2 (00208033) never raises `rf_we`.
  - `rst` asserted mid-MEMORY returns `pc`=RESET_PC and drops `dmem_req` in the next cycle.
